// File: rtl/i2s_rx_pkg.sv
// Shared audio definitions for the I2S receiver.
// Channel encoding matches the wclk level.
package i2s_rx_pkg;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } chan_e;

  localparam int SAMPLE_DEPTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF   = 4;

endpackage

// File: rtl/i2s_rx_if.sv
// Valid/ready stream carrying one stereo pair.
// Left word in the upper half of data.
interface i2s_rx_if #(
  parameter int W = 32
) ();

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/i2s_rx_sync_fifo.sv
// Stereo pair FIFO with a valid/ready read port.
// A push into a full FIFO is refused unless a pop happens that cycle.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  output logic         drop,
  i2s_rx_if.master     q
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         empty;
  logic         full;
  logic         pop;
  logic         wr;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW])
              && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = q.valid & q.ready;
  assign wr    = push & (~full | pop);
  assign drop  = push & full & ~pop;

  assign q.valid = ~empty;
  assign q.data  = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversampled bclk/wclk/din on mclk,
// assembles left/right words and buffers stereo pairs.
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int SAMPLE_DEPTH = SAMPLE_DEPTH_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                    mclk,
  input  logic                    reset,
  input  logic                    wclk,
  input  logic                    bclk,
  input  logic                    din,
  output logic [SAMPLE_DEPTH-1:0] out_l,
  output logic [SAMPLE_DEPTH-1:0] out_r,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  output logic                    locked
);

  localparam int SD = SAMPLE_DEPTH;
  localparam int CW = $clog2(SD + 2);
  localparam logic [CW-1:0] FULL = CW'(SD);

  logic [1:0]    wclk_s;
  logic [1:0]    bclk_s;
  logic [1:0]    din_s;
  logic          bclk_q;
  logic          ws_q;
  logic          ws_seen;
  logic [CW-1:0] cnt;
  logic [SD-2:0] sr;
  chan_e         ch;
  logic [SD-1:0] pend;
  logic          pend_v;
  logic          push;
  logic [2*SD-1:0] pair;
  logic          drop;

  logic          rise;
  logic          ws;
  logic          change;
  logic [CW-1:0] k;
  logic          capture;
  logic [SD-1:0] word;

  i2s_rx_if #(.W(2*SD)) q ();

  assign rise    = bclk_s[1] & ~bclk_q;
  assign ws      = wclk_s[1];
  assign change  = ws_seen & (ws != ws_q);
  assign k       = cnt + 1'b1;
  assign capture = rise & locked & (k == FULL);
  assign word    = {sr, din_s[1]};

  // The capture below uses ch before it is relatched, so a word
  // ending on a change rise goes to the half that just closed.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      wclk_s   <= '0;
      bclk_s   <= '0;
      din_s    <= '0;
      bclk_q   <= 1'b0;
      ws_q     <= 1'b0;
      ws_seen  <= 1'b0;
      cnt      <= '0;
      sr       <= '0;
      ch       <= LEFT;
      pend     <= '0;
      pend_v   <= 1'b0;
      push     <= 1'b0;
      pair     <= '0;
      locked   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wclk_s   <= {wclk_s[0], wclk};
      bclk_s   <= {bclk_s[0], bclk};
      din_s    <= {din_s[0], din};
      bclk_q   <= bclk_s[1];
      push     <= 1'b0;
      overflow <= drop;
      if (rise) begin
        sr      <= word[SD-2:0];
        ws_q    <= ws;
        ws_seen <= 1'b1;
        if (change) begin
          cnt    <= '0;
          ch     <= chan_e'(ws);
          locked <= 1'b1;
        end else if (cnt != FULL) begin
          cnt <= k;
        end
        if (capture) begin
          if (ch == LEFT) begin
            pend   <= word;
            pend_v <= 1'b1;
          end else if (pend_v) begin
            pair   <= {pend, word};
            push   <= 1'b1;
            pend_v <= 1'b0;
          end
        end
      end
    end
  end

  sync_fifo #(
    .W     (2*SD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (mclk),
    .rst   (reset),
    .push  (push),
    .wdata (pair),
    .drop  (drop),
    .q     (q)
  );

  assign q.ready   = out_ready;
  assign out_valid = q.valid;
  assign out_l     = q.data[2*SD-1:SD];
  assign out_r     = q.data[SD-1:0];

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: an I2S line generator driven
// slot by slot, a pop recorder, and per-scenario checks.
module tb_i2s_rx;

  logic mclk = 1'b0;
  logic reset;
  logic wclk;
  logic bclk;
  logic din;
  logic overflow;
  logic locked;

  i2s_rx_if #(.W(32)) bus ();

  always #5 mclk = ~mclk;

  i2s_rx #(
    .SAMPLE_DEPTH (16),
    .FIFO_DEPTH   (4)
  ) dut (
    .mclk      (mclk),
    .reset     (reset),
    .wclk      (wclk),
    .bclk      (bclk),
    .din       (din),
    .out_l     (bus.data[31:16]),
    .out_r     (bus.data[15:0]),
    .out_valid (bus.valid),
    .out_ready (bus.ready),
    .overflow  (overflow),
    .locked    (locked)
  );

  int n_tests;
  int n_fail;
  int hp;
  int ovf_cnt;
  logic carry;
  logic [15:0] pl [$];
  logic [15:0] pr [$];
  longint pt [$];

  always @(negedge mclk) begin
    if (!reset && bus.valid && bus.ready) begin
      pl.push_back(bus.data[31:16]);
      pr.push_back(bus.data[15:0]);
      pt.push_back(longint'($time));
    end
    if (overflow) ovf_cnt++;
  end

  task automatic clear_log();
    pl.delete();
    pr.delete();
    pt.delete();
    ovf_cnt = 0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge mclk);
    #1 bus.ready = v;
  endtask

  task automatic send_slot(input logic w, input logic d);
    @(negedge mclk);
    bclk = 1'b0;
    wclk = w;
    din  = d;
    repeat (hp) @(negedge mclk);
    bclk = 1'b1;
    repeat (hp - 1) @(negedge mclk);
  endtask

  // Bit at slot position p (1 = MSB) of a half with word w.
  function automatic logic bit_at(input logic [15:0] w,
                                  input int p,
                                  input logic tr);
    if (p <= 16) return w[16 - p];
    return tr;
  endfunction

  task automatic send_half(input logic c, input logic [15:0] w,
                           input int n, input logic tr,
                           input logic slot0);
    if (slot0) send_slot(c, carry);
    for (int s = 1; s < n; s++) send_slot(c, bit_at(w, s, tr));
    carry = bit_at(w, n, tr);
  endtask

  // Leaves the line just before the next left slot 0.
  task automatic send_frame_open(input logic [15:0] l,
                                 input logic [15:0] r,
                                 input int n, input logic tr);
    send_half(1'b0, l, n, tr, 1'b0);
    send_half(1'b1, r, n, tr, 1'b1);
  endtask

  task automatic send_frame(input logic [15:0] l,
                            input logic [15:0] r,
                            input int n, input logic tr);
    send_frame_open(l, r, n, tr);
    send_slot(1'b0, carry);
  endtask

  task automatic close_rise();
    @(negedge mclk);
    bclk = 1'b0;
    wclk = 1'b0;
    din  = carry;
    repeat (hp) @(negedge mclk);
    bclk = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge mclk);
    n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", bus.valid); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b exp 0", overflow); end
    n_tests++; if (bus.data[31:16] !== 16'h0) begin n_fail++; $display("FAIL rst_out_l got %h exp 0000", bus.data[31:16]); end
    n_tests++; if (bus.data[15:0] !== 16'h0) begin n_fail++; $display("FAIL rst_out_r got %h exp 0000", bus.data[15:0]); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked got %b exp 0", locked); end
    reset = 1'b0;
    clear_log();
    send_slot(1'b0, 1'b0);
    send_frame(16'hDEAD, 16'hBEEF, 16, 1'b0);
    repeat (8) @(negedge mclk);
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_after_change got %b exp 1", locked); end
    n_tests++; if (pl.size() !== 0) begin n_fail++; $display("FAIL prelock_discard got %0d pops exp 0", pl.size()); end
  endtask

  task automatic test_continuous();
    clear_log();
    for (int i = 0; i < 3; i++) send_frame(16'h8000, 16'h8000, 16, 1'b0);
    repeat (8) @(negedge mclk);
    n_tests++; if (pl.size() !== 3) begin n_fail++; $display("FAIL cont_count got %0d exp 3", pl.size()); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (pl[i] !== 16'h8000) begin n_fail++; $display("FAIL cont_l[%0d] got %h exp 8000", i, pl[i]); end
      n_tests++; if (pr[i] !== 16'h8000) begin n_fail++; $display("FAIL cont_r[%0d] got %h exp 8000", i, pr[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      n_tests++; if (pt[i] - pt[i-1] !== 64'd2560) begin n_fail++; $display("FAIL cont_period[%0d] got %0d exp 2560", i, pt[i] - pt[i-1]); end
    end
    n_tests++; if (ovf_cnt !== 0) begin n_fail++; $display("FAIL cont_ovf got %0d exp 0", ovf_cnt); end
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL cont_locked got %b exp 1", locked); end
  endtask

  task automatic test_latency();
    clear_log();
    send_frame_open(16'h1234, 16'hABCD, 16, 1'b0);
    close_rise();
    repeat (3) @(posedge mclk);
    #1;
    n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL lat_early_valid got %b exp 0", bus.valid); end
    @(posedge mclk);
    #1;
    n_tests++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid got %b exp 1", bus.valid); end
    n_tests++; if (bus.data[31:16] !== 16'h1234) begin n_fail++; $display("FAIL lat_out_l got %h exp 1234", bus.data[31:16]); end
    n_tests++; if (bus.data[15:0] !== 16'hABCD) begin n_fail++; $display("FAIL lat_out_r got %h exp abcd", bus.data[15:0]); end
    repeat (8) @(negedge mclk);
    n_tests++; if (pl.size() !== 1) begin n_fail++; $display("FAIL lat_pops got %0d exp 1", pl.size()); end
  endtask

  task automatic test_overflow();
    clear_log();
    set_ready(1'b0);
    for (int i = 1; i <= 6; i++) begin
      send_frame(16'h0010 + 16'(i), 16'hA000 + 16'(i), 16, 1'b0);
      repeat (8) @(negedge mclk);
      n_tests++; if (ovf_cnt !== ((i > 4) ? i - 4 : 0)) begin n_fail++; $display("FAIL ovf_frame%0d got %0d exp %0d", i, ovf_cnt, (i > 4) ? i - 4 : 0); end
    end
    n_tests++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL ovf_hold_valid got %b exp 1", bus.valid); end
    n_tests++; if (bus.data[31:16] !== 16'h0011) begin n_fail++; $display("FAIL ovf_head_l got %h exp 0011", bus.data[31:16]); end
    n_tests++; if (bus.data[15:0] !== 16'hA001) begin n_fail++; $display("FAIL ovf_head_r got %h exp a001", bus.data[15:0]); end
    set_ready(1'b1);
    repeat (10) @(negedge mclk);
    n_tests++; if (pl.size() !== 4) begin n_fail++; $display("FAIL ovf_drain_count got %0d exp 4", pl.size()); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (pl[i] !== 16'h0011 + 16'(i)) begin n_fail++; $display("FAIL ovf_drain_l[%0d] got %h exp %h", i, pl[i], 16'h0011 + 16'(i)); end
      n_tests++; if (pr[i] !== 16'hA001 + 16'(i)) begin n_fail++; $display("FAIL ovf_drain_r[%0d] got %h exp %h", i, pr[i], 16'hA001 + 16'(i)); end
    end
  endtask

  task automatic test_full_pushpop();
    clear_log();
    set_ready(1'b0);
    for (int i = 1; i <= 4; i++) send_frame(16'h0020 + 16'(i), 16'hB020 + 16'(i), 16, 1'b0);
    repeat (8) @(negedge mclk);
    n_tests++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL full_valid got %b exp 1", bus.valid); end
    send_frame_open(16'h0025, 16'hB025, 16, 1'b0);
    close_rise();
    repeat (3) @(posedge mclk);
    #1 bus.ready = 1'b1;
    @(posedge mclk);
    #1 bus.ready = 1'b0;
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pp_ovf got %b exp 0", overflow); end
    repeat (4) @(negedge mclk);
    n_tests++; if (ovf_cnt !== 0) begin n_fail++; $display("FAIL full_pp_ovf_cnt got %0d exp 0", ovf_cnt); end
    n_tests++; if (pl.size() !== 1) begin n_fail++; $display("FAIL full_pp_pops got %0d exp 1", pl.size()); end
    set_ready(1'b1);
    repeat (10) @(negedge mclk);
    n_tests++; if (pl.size() !== 5) begin n_fail++; $display("FAIL full_drain_count got %0d exp 5", pl.size()); end
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (pl[i] !== 16'h0021 + 16'(i)) begin n_fail++; $display("FAIL full_l[%0d] got %h exp %h", i, pl[i], 16'h0021 + 16'(i)); end
      n_tests++; if (pr[i] !== 16'hB021 + 16'(i)) begin n_fail++; $display("FAIL full_r[%0d] got %h exp %h", i, pr[i], 16'hB021 + 16'(i)); end
    end
  endtask

  task automatic test_wide();
    clear_log();
    hp = 2;
    send_frame(16'h00FF, 16'h5A5A, 32, 1'b1);
    hp = 4;
    repeat (8) @(negedge mclk);
    n_tests++; if (pl.size() !== 1) begin n_fail++; $display("FAIL wide_count got %0d exp 1", pl.size()); end
    n_tests++; if (pl[0] !== 16'h00FF) begin n_fail++; $display("FAIL wide_l got %h exp 00ff", pl[0]); end
    n_tests++; if (pr[0] !== 16'h5A5A) begin n_fail++; $display("FAIL wide_r got %h exp 5a5a", pr[0]); end
    n_tests++; if (ovf_cnt !== 0) begin n_fail++; $display("FAIL wide_ovf got %0d exp 0", ovf_cnt); end
  endtask

  task automatic test_midreset();
    clear_log();
    set_ready(1'b0);
    send_frame(16'h1111, 16'h2222, 16, 1'b0);
    repeat (8) @(negedge mclk);
    n_tests++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b exp 1", bus.valid); end
    for (int s = 1; s <= 8; s++) send_slot(1'b0, 1'b1);
    @(negedge mclk);
    reset = 1'b1;
    #1;
    n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b exp 0", bus.valid); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mid_rst_locked got %b exp 0", locked); end
    n_tests++; if (bus.data[31:16] !== 16'h0) begin n_fail++; $display("FAIL mid_rst_out_l got %h exp 0000", bus.data[31:16]); end
    repeat (3) @(negedge mclk);
    reset = 1'b0;
    set_ready(1'b1);
    clear_log();
    carry = 1'b0;
    send_slot(1'b0, 1'b0);
    send_frame(16'hDEAD, 16'hBEEF, 16, 1'b0);
    send_frame(16'h3C3C, 16'hC3C3, 16, 1'b0);
    repeat (8) @(negedge mclk);
    n_tests++; if (pl.size() !== 1) begin n_fail++; $display("FAIL mid_relock_count got %0d exp 1", pl.size()); end
    n_tests++; if (pl[0] !== 16'h3C3C) begin n_fail++; $display("FAIL mid_relock_l got %h exp 3c3c", pl[0]); end
    n_tests++; if (pr[0] !== 16'hC3C3) begin n_fail++; $display("FAIL mid_relock_r got %h exp c3c3", pr[0]); end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    ovf_cnt   = 0;
    hp        = 4;
    carry     = 1'b0;
    reset     = 1'b1;
    wclk      = 1'b0;
    bclk      = 1'b1;
    din       = 1'b0;
    bus.ready = 1'b1;
    test_reset();
    test_continuous();
    test_latency();
    test_overflow();
    test_full_pushpop();
    test_wide();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
